instruction_fetch_unit: RTL



---
 rtl/instruction_fetch_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, requests a synchronous-read
// program memory, and buffers returned words in a small circular prefetch
// queue that feeds the decoder over a valid/ready handshake.
//   clock, reset_n          : clock, asynchronous active-low reset
//   pm_req, pm_addr         : program memory read request / address (= fetch_pc)
//   pm_rdata                : read data, one cycle after the request
//   instr, instr_pc         : queue head word and the address it came from
//   instr_valid/instr_ready : head handshake, pop when both are high
//   redirect, redirect_pc   : branch-taken pulse and target
//   halt                    : suppresses new requests while high
//   fetch_pc                : next address to fetch
module instruction_fetch_unit #(
    parameter int unsigned INSTR_W = 31,
    parameter int unsigned PC_W    = 8,
    parameter int unsigned DEPTH   = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic               pm_req,
    output logic [PC_W-1:0]    pm_addr,
    input  logic [INSTR_W-1:0] pm_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic [PC_W-1:0]    fetch_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_FULL   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

    logic [1:0]         state, state_nxt;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic               inflight;
    logic [PC_W-1:0]    infl_pc;
    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic [PC_W-1:0]    q_pc    [DEPTH];

    logic               pop, push;
    logic [OCC_W-1:0]   occ, count_nxt, occ_nxt;

    assign instr_valid = (count != '0);
    assign instr       = q_instr[rd_ptr];
    assign instr_pc    = q_pc[rd_ptr];
    assign pm_addr     = fetch_pc;

    // A handshake in a redirect cycle is dropped along with the flush.
    assign pop  = instr_valid && instr_ready && !redirect;
    // Returns landing on a redirect edge or in the FLUSH cycle are stale.
    assign push = inflight && !redirect && (state != ST_FLUSH);

    // Occupancy counts the in-flight return; a same-cycle pop frees its slot
    // at the edge the return lands, which sustains one word per cycle.
    assign occ    = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
    assign pm_req = reset_n && !halt && !redirect && (occ < OCC_W'(DEPTH));

    assign count_nxt = redirect ? '0 : OCC_W'(count) + OCC_W'(push) - OCC_W'(pop);
    assign occ_nxt   = count_nxt + OCC_W'(pm_req);

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_RUN;
        else          state <= state_nxt;
    end

    // FSM next state, priority redirect > halt > space > full.
    always_comb begin
        state_nxt = state;
        if (redirect)                      state_nxt = ST_FLUSH;
        else if (halt)                     state_nxt = ST_HALTED;
        else if (occ_nxt < OCC_W'(DEPTH))  state_nxt = ST_RUN;
        else                               state_nxt = ST_FULL;
    end

    // Fetch PC, in-flight tracking and prefetch queue.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= '0;
            inflight <= 1'b0;
            infl_pc  <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else begin
            inflight <= pm_req;
            count    <= CNT_W'(count_nxt);
            if (pm_req) infl_pc <= fetch_pc;
            if (redirect) begin
                fetch_pc <= redirect_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (pm_req) fetch_pc <= fetch_pc + PC_W'(1);
                if (pop)    rd_ptr   <= rd_ptr + PTR_W'(1);
                if (push) begin
                    q_instr[wr_ptr] <= pm_rdata;
                    q_pc[wr_ptr]    <= infl_pc;
                    wr_ptr          <= wr_ptr + PTR_W'(1);
                end
            end
        end
    end

    a_count_bound: assert property (@(posedge clock) disable iff (!reset_n)
        count <= CNT_W'(DEPTH));
    a_valid_match: assert property (@(posedge clock) disable iff (!reset_n)
        instr_valid == (count != '0));

endmodule
